pipe_hfilter: RTL
=================

Name: pipe_hfilter

Overview:
- Downstream consumer of the 18-bit generic pipe in the vision datapath.
- Pulls pixels from the pipe read port with the req/ack handshake and applies a 3-tap horizontal [1 2 1]/4 smoothing kernel along each image line.
- Replicates the edge pixel at line start and line end.
- Presents filtered pixels on a valid/ready stream with an end-of-line marker, for the next vision stage.

Parameters:
- LENGTH, 18: pixel/word width in bits; matches the pipe data width.
- LINE_WIDTH, 640: pixels per line; legal range is 2 to 65535.
- COL_W, 16: width of the column counter; must satisfy 2^COL_W >= LINE_WIDTH.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pipe_read_req  output  1  request a word from the pipe.
- pipe_read_ack  input  1  pipe presents a valid word this cycle.
- pipe_read_data  input  LENGTH  pixel from the pipe.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the current output.
- out_data  output  LENGTH  filtered pixel.
- out_last  output  1  qualifies out_data as the final pixel of a line.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; these are fixed.
- Reset values:
  - pipe_read_req=0, out_valid=0, out_data=0, out_last=0.
  - state=FETCH, col=0, prev=cur=0.
  - pipe_read_req is 0 during the reset cycle and 1 in the first cycle after rst falls.
- Pipe transfer: occurs on a rising edge where pipe_read_req && pipe_read_ack. pipe_read_data is sampled on that edge.
  - Ack with req low is ignored.
  - req stays high across cycles until the transfer occurs.
- Output transfer: occurs on a rising edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last are held stable.
- Filter function: f(a,b,c) = (a + 2*b + c + 2) >> 2.
  - Computed in LENGTH+2 bits, then truncated to LENGTH bits.
  - Never overflows; all-ones inputs give all-ones output.
- State FETCH (pipe_read_req=1, out_valid=0). On a pipe transfer with pixel p:
  - col==0: prev<=p, cur<=p, col<=1, stay in FETCH. No output is produced.
  - 0<col<LINE_WIDTH-1: out_data<=f(prev,cur,p), out_last<=0, prev<=cur, cur<=p, col<=col+1, go to EMIT.
  - col==LINE_WIDTH-1: same as the previous case, plus edge_pend<=1 and col<=0, go to EMIT.
- State EMIT (pipe_read_req=0, out_valid=1). On an output transfer:
  - edge_pend==1: out_data<=f(prev,cur,cur), out_last<=1, edge_pend<=0, go to EDGE.
  - otherwise: go to FETCH.
- State EDGE (pipe_read_req=0, out_valid=1, out_last=1). On an output transfer, go to FETCH; the next pixel starts a new line.
- Latency: the output for pixel k becomes valid in the cycle after the pipe transfer of pixel k+1. The last pixel's output follows one accepted output later.
- Throughput: at most one pixel per 2 cycles. There is no overlap between FETCH and EMIT.
- Ordering: exactly LINE_WIDTH outputs per line, in order. out_last is set only on the LINE_WIDTH-th output.
- Reset mid-line: the partial line is discarded and any pending output is dropped. The next accepted pixel is treated as col 0.
- pipe_read_ack held high continuously: exactly one word is consumed per FETCH transfer. No words are consumed outside FETCH.

Test Plan:
- LINE_WIDTH=4, inputs 10,20,30,40, out_ready=1 -> outputs 13,20,30,38; out_last=1 only on 38; col returns to 0.
- Two back-to-back lines (10,20,30,40 then 100,100,100,100) -> 13,20,30,38 then 100,100,100,100. The second line must not take prev from the first line.
- out_ready low for 5 cycles while out_valid=1 -> out_data and out_last are stable, pipe_read_req=0, and no pipe words are consumed. Output resumes correctly when out_ready rises.
- pipe_read_ack delayed 3 cycles after req -> req held at 1 throughout; exactly one word captured; data sampled on the ack edge.
- All inputs 2^18-1 -> every output is 262143 (no overflow or wrap).
- rst asserted after the 2nd pixel of a line -> outputs cleared next cycle and req=1 the cycle after rst falls. A new line 10,20,30,40 then yields 13,20,30,38.

Source files
------------

// File: rtl/pipe_hfilter.sv
// Purpose : 3-tap [1 2 1]/4 horizontal smoothing filter that pulls pixels from the
//           generic pipe (req/ack) and emits filtered pixels with an end-of-line marker.
// Latency : output k becomes valid the cycle after the pipe transfer of pixel k+1;
//           the last pixel of a line follows one accepted output later.
// Backpressure: out_ready low holds out_data/out_last and stops pipe reads (req=0).
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   pipe_read_req  request a word from the pipe (high only in FETCH)
//   pipe_read_ack  pipe presents a valid word this cycle
//   pipe_read_data pixel from the pipe, sampled on the req&&ack edge
//   out_valid      out_data is valid
//   out_ready      downstream accepts the current output
//   out_data       filtered pixel
//   out_last       final pixel of a line
module pipe_hfilter #(
    parameter int LENGTH     = 18,
    parameter int LINE_WIDTH = 640,
    parameter int COL_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              pipe_read_req,
    input  logic              pipe_read_ack,
    input  logic [LENGTH-1:0] pipe_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EMIT  = 2'd1,
        EDGE  = 2'd2
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic [LENGTH-1:0] prev, prev_nxt;
    logic [LENGTH-1:0] cur, cur_nxt;
    logic [LENGTH-1:0] data_q, data_nxt;
    logic              last_q, last_nxt;
    logic              edge_pend, edge_pend_nxt;

    logic              pipe_xfer;
    logic              out_xfer;

    // (a + 2b + c + 2) >> 2 evaluated with two guard bits; the maximum sum is
    // 4*(2^LENGTH-1)+2 which fits, and the shifted result fits in LENGTH bits.
    function automatic logic [LENGTH-1:0] smooth(
        input logic [LENGTH-1:0] a,
        input logic [LENGTH-1:0] b,
        input logic [LENGTH-1:0] c
    );
        logic [LENGTH+1:0] sum;
        sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + (LENGTH+2)'(2);
        return sum[LENGTH+1:2];
    endfunction

    // Request is gated by rst so it is already low in the reset cycle itself.
    assign pipe_read_req = (state == FETCH) && !rst;
    assign out_valid     = (state != FETCH);
    assign out_data      = data_q;
    assign out_last      = last_q;

    assign pipe_xfer = pipe_read_req && pipe_read_ack;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        prev_nxt      = prev;
        cur_nxt       = cur;
        data_nxt      = data_q;
        last_nxt      = last_q;
        edge_pend_nxt = edge_pend;

        unique case (state)
            FETCH: begin
                if (pipe_xfer) begin
                    if (col == '0) begin
                        // Line start: replicate the first pixel into the left tap.
                        prev_nxt = pipe_read_data;
                        cur_nxt  = pipe_read_data;
                        col_nxt  = COL_ONE;
                    end else begin
                        data_nxt  = smooth(prev, cur, pipe_read_data);
                        last_nxt  = 1'b0;
                        prev_nxt  = cur;
                        cur_nxt   = pipe_read_data;
                        state_nxt = EMIT;
                        if (col == LAST_COL) begin
                            // One more output (right edge) owed after this one.
                            edge_pend_nxt = 1'b1;
                            col_nxt       = '0;
                        end else begin
                            col_nxt = col + COL_ONE;
                        end
                    end
                end
            end

            EMIT: begin
                if (out_xfer) begin
                    if (edge_pend) begin
                        // Right edge: replicate the last pixel into the right tap.
                        data_nxt      = smooth(prev, cur, cur);
                        last_nxt      = 1'b1;
                        edge_pend_nxt = 1'b0;
                        state_nxt     = EDGE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end

            EDGE: begin
                if (out_xfer) begin
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            col       <= '0;
            prev      <= '0;
            cur       <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            edge_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            prev      <= prev_nxt;
            cur       <= cur_nxt;
            data_q    <= data_nxt;
            last_q    <= last_nxt;
            edge_pend <= edge_pend_nxt;
        end
    end

endmodule
